// File: rtl/stage_ex_md.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stage_ex_md                                                |
// | Description : Execute stage with single-cycle ALU and an iterative       |
// |               radix-2 multiply/divide unit (IDLE/BUSY/DONE FSM).         |
// |               Results land in a registered EX->MA output stage.          |
// | Ports       : clk, rst_i (async, active-high)                            |
// |               squash_i   - kill instruction in this stage                |
// |               stall_i    - downstream stall, holds output register       |
// |               in_valid_i, in_op1_i, in_op2_i, in_alu_fun_i, in_md_i,     |
// |               in_md_fun_i, in_tag_i - incoming instruction               |
// |               ex_stall_o - upstream must hold in_* while high            |
// |               out_valid_o, out_result_o, out_tag_o - registered result   |
// | Option      : STAGE_EX_MUL_1CYC_EN - combinational multiplier; MUL*      |
// |               ops then complete with ALU timing. Divides stay iterative. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stage_ex_md #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             squash_i,
  input  logic             stall_i,
  input  logic             in_valid_i,
  input  logic [XLEN-1:0]  in_op1_i,
  input  logic [XLEN-1:0]  in_op2_i,
  input  logic [3:0]       in_alu_fun_i,
  input  logic             in_md_i,
  input  logic [2:0]       in_md_fun_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             ex_stall_o,
  output logic             out_valid_o,
  output logic [XLEN-1:0]  out_result_o,
  output logic [TAG_W-1:0] out_tag_o
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;     // product high half / partial remainder
  logic [XLEN-1:0]  lo_q, lo_d;     // multiplier->product low / dividend->quotient
  logic [XLEN-1:0]  opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [2:0]       fun_q, fun_d;
  logic             neg_q, neg_d;   // negate the selected result in DONE
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  // ---------------------------------------------------------------- ALU
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] alu_res;

  always_comb begin
    shamt   = in_op2_i[SH_W-1:0];
    alu_res = '0;
    case (in_alu_fun_i)
      4'b0000: alu_res = in_op1_i + in_op2_i;
      4'b1000: alu_res = in_op1_i - in_op2_i;
      4'b0001: alu_res = in_op1_i << shamt;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(in_op1_i) < $signed(in_op2_i)};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, in_op1_i < in_op2_i};
      4'b0100: alu_res = in_op1_i ^ in_op2_i;
      4'b0101: alu_res = in_op1_i >> shamt;
      4'b1101: alu_res = $unsigned($signed(in_op1_i) >>> shamt);
      4'b0110: alu_res = in_op1_i | in_op2_i;
      4'b0111: alu_res = in_op1_i & in_op2_i;
      4'b1001: alu_res = in_op1_i;
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------- MD decode
  logic            op1_signed, op2_signed;
  logic            s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            is_div_in, is_rem_in, div_zero;

  always_comb begin
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    case (in_md_fun_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin op1_signed = 1'b1; op2_signed = 1'b1; end
      3'd2:                   op1_signed = 1'b1;
      default:                ;
    endcase
    s1        = in_op1_i[XLEN-1] & op1_signed;
    s2        = in_op2_i[XLEN-1] & op2_signed;
    mag1      = s1 ? -in_op1_i : in_op1_i;
    mag2      = s2 ? -in_op2_i : in_op2_i;
    is_div_in = in_md_fun_i[2];
    is_rem_in = in_md_fun_i[2] & in_md_fun_i[1];
    div_zero  = (in_op2_i == '0);
  end

  // Result of anything that completes in one cycle (ALU, optionally MUL*).
  logic [XLEN-1:0] fast_res;
  logic            md_iter;   // this op goes through the iterative unit

`ifdef STAGE_EX_MUL_1CYC_EN
  logic [2*XLEN-1:0] fm_a, fm_b, fm_p;

  always_comb begin
    fm_a = {{XLEN{s1}}, in_op1_i};
    fm_b = {{XLEN{s2}}, in_op2_i};
    fm_p = fm_a * fm_b;   // low 2*XLEN bits of the extended product are exact
    if (in_md_i) begin
      fast_res = (in_md_fun_i[1:0] == 2'd0) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    end else begin
      fast_res = alu_res;
    end
  end

  assign md_iter = in_md_i & in_md_fun_i[2];
`else
  assign fast_res = alu_res;
  assign md_iter  = in_md_i;
`endif

  logic md_start;
  assign md_start   = in_valid_i & md_iter & ~squash_i;
  assign ex_stall_o = ~rst_i & ((state_q == ST_BUSY) | ((state_q == ST_IDLE) & md_start));

  // ------------------------------------------------------ iteration step
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    // When div_ge holds the true difference is below 2^XLEN, so the
    // truncated subtraction is exact.
    div_sub   = div_shift[XLEN-1:0] - opb_q;
  end

  // --------------------------------------------------- result selection
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   div_raw, md_res;

  always_comb begin
    prod_s  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    div_raw = fun_q[1] ? hi_q : lo_q;
    if (fun_q[2]) begin
      md_res = neg_q ? -div_raw : div_raw;
    end else if (fun_q[1:0] == 2'd0) begin
      md_res = prod_s[XLEN-1:0];
    end else begin
      md_res = prod_s[2*XLEN-1:XLEN];
    end
  end

  // ------------------------------------------------- next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    opb_d        = opb_q;
    fun_d        = fun_q;
    neg_d        = neg_q;
    tag_d        = tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = is_div_in ? mag1 : mag2;
          opb_d   = is_div_in ? mag2 : mag1;
          fun_d   = in_md_fun_i;
          tag_d   = in_tag_i;
          // Divide-by-zero quotient stays all-ones; remainder follows the
          // dividend sign so it reproduces the dividend exactly.
          if (is_rem_in) begin
            neg_d = s1;
          end else begin
            neg_d = (s1 ^ s2) & ~(is_div_in & div_zero);
          end
        end
        if (!stall_i) begin
          out_valid_d  = in_valid_i & ~squash_i & ~md_iter;
          out_result_d = fast_res;
          out_tag_d    = in_tag_i;
        end
      end

      ST_BUSY: begin
        if (squash_i) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fun_q[2]) begin
            hi_d = div_ge ? div_sub : div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = ST_DONE;
          end
        end
        if (!stall_i) begin
          out_valid_d = 1'b0;
        end
      end

      ST_DONE: begin
        if (squash_i) begin
          state_d = ST_IDLE;
          if (!stall_i) begin
            out_valid_d = 1'b0;
          end
        end else if (!stall_i) begin
          state_d      = ST_IDLE;
          out_valid_d  = 1'b1;
          out_result_d = md_res;
          out_tag_d    = tag_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      opb_q        <= '0;
      fun_q        <= '0;
      neg_q        <= 1'b0;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      opb_q        <= opb_d;
      fun_q        <= fun_d;
      neg_q        <= neg_d;
      tag_q        <= tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign out_tag_o    = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_ex_md.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stage_ex_md                                             |
// | Description : Directed bench for stage_ex_md (XLEN=32). Expected results |
// |               are queued when issued and popped by an output monitor.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_stage_ex_md;
  localparam int XLEN  = 32;
  localparam int TAG_W = 16;
`ifdef STAGE_EX_MUL_1CYC_EN
  localparam int MUL_STALL = 0;
`else
  localparam int MUL_STALL = 33;
`endif

  logic             clk;
  logic             rst_i;
  logic             squash_i;
  logic             stall_i;
  logic             in_valid_i;
  logic [XLEN-1:0]  in_op1_i;
  logic [XLEN-1:0]  in_op2_i;
  logic [3:0]       in_alu_fun_i;
  logic             in_md_i;
  logic [2:0]       in_md_fun_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             ex_stall_o;
  logic             out_valid_o;
  logic [XLEN-1:0]  out_result_o;
  logic [TAG_W-1:0] out_tag_o;

  stage_ex_md #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .squash_i     (squash_i),
    .stall_i      (stall_i),
    .in_valid_i   (in_valid_i),
    .in_op1_i     (in_op1_i),
    .in_op2_i     (in_op2_i),
    .in_alu_fun_i (in_alu_fun_i),
    .in_md_i      (in_md_i),
    .in_md_fun_i  (in_md_fun_i),
    .in_tag_i     (in_tag_i),
    .ex_stall_o   (ex_stall_o),
    .out_valid_o  (out_valid_o),
    .out_result_o (out_result_o),
    .out_tag_o    (out_tag_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string            name;
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Output monitor: a new result is registered on every edge where stall_i
  // was low before the edge and out_valid_o is high after it.
  always @(posedge clk) begin : mon
    logic stall_pre;
    exp_t e;
    stall_pre = stall_i;
    #1;
    if (!rst_i && !stall_pre && out_valid_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got result 0x%0h tag 0x%0h, required no output",
                 out_result_o, out_tag_o);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"}, out_result_o, e.res);
        check({e.name, "_tag"}, 32'(out_tag_o), 32'(e.tag));
      end
    end
  end

  task automatic drive(input logic md, input logic [3:0] fun, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    in_valid_i   = 1'b1;
    in_md_i      = md;
    in_alu_fun_i = fun;
    in_md_fun_i  = fun[2:0];
    in_op1_i     = a;
    in_op2_i     = b;
    in_tag_i     = tag;
  endtask

  task automatic expect_out(input string name, input logic [XLEN-1:0] v, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.name = name;
    e.res  = v;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // Issue one instruction and hold it until the stage releases it; returns
  // right after the edge that consumes it.
  task automatic send(input string name, input logic md, input logic [3:0] fun,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] expv,
                      input int exp_stall);
    int stalls;
    bit done;
    @(negedge clk);
    drive(md, fun, a, b, tag);
    expect_out(name, expv, tag);
    stalls = 0;
    done   = 1'b0;
    #1;
    for (int k = 0; k < 100 && !done; k++) begin
      if (!ex_stall_o && !stall_i) begin
        done = 1'b1;
      end else begin
        if (ex_stall_o) stalls++;
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_release: ex_stall_o still high after 100 cycles, required release", name);
    end
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid_i = 1'b0;
    in_md_i    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i    = 1'b1;
    squash_i = 1'b0;
    stall_i  = 1'b0;
    drive(1'b1, 4'd4, 32'd7, 32'd3, 16'hDEAD);   // MD request held during reset

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_result", out_result_o, 32'd0);
    check("rst_out_tag", 32'(out_tag_o), 32'd0);
    check("rst_ex_stall", 32'(ex_stall_o), 32'd0);
    @(negedge clk);
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    in_md_i    = 1'b0;

    // ALU: back-to-back ADD and SRA, then the remaining functions
    send("add_ovf", 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h1, 16'h0001, 32'h80000000, 0);
    send("sra", 1'b0, 4'b1101, 32'h80000000, 32'h4, 16'h0002, 32'hF8000000, 0);
    send("sub", 1'b0, 4'b1000, 32'd5, 32'd7, 16'h0003, 32'hFFFFFFFE, 0);
    send("slt", 1'b0, 4'b0010, 32'hFFFFFFFF, 32'h1, 16'h0004, 32'h1, 0);
    send("sltu", 1'b0, 4'b0011, 32'hFFFFFFFF, 32'h1, 16'h0005, 32'h0, 0);
    send("xor", 1'b0, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0006, 32'h0FF00FF0, 0);
    send("or", 1'b0, 4'b0110, 32'hF0F0F0F0, 32'h0F000000, 16'h0007, 32'hFFF0F0F0, 0);
    send("and", 1'b0, 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0008, 32'hF000F000, 0);
    send("sll_mask", 1'b0, 4'b0001, 32'h1, 32'h3F, 16'h0009, 32'h80000000, 0);
    send("srl_mask", 1'b0, 4'b0101, 32'h80000000, 32'h21, 16'h000A, 32'h40000000, 0);
    send("copy1", 1'b0, 4'b1001, 32'h12345678, 32'hAAAA5555, 16'h000B, 32'h12345678, 0);

    // Divide by zero with full latency
    send("div_by0", 1'b1, 4'd4, 32'd7, 32'd0, 16'h0010, 32'hFFFFFFFF, 33);
    #1;
    check("div_by0_latency_valid", 32'(out_valid_o), 32'd1);
    send("rem_by0", 1'b1, 4'd6, 32'd7, 32'd0, 16'h0011, 32'd7, 33);
    send("rem_neg_by0", 1'b1, 4'd6, 32'hFFFFFFF9, 32'd0, 16'h0012, 32'hFFFFFFF9, 33);

    // Signed overflow and high-half multiplies
    send("div_ovf", 1'b1, 4'd4, 32'h80000000, 32'hFFFFFFFF, 16'h0020, 32'h80000000, 33);
    send("rem_ovf", 1'b1, 4'd6, 32'h80000000, 32'hFFFFFFFF, 16'h0021, 32'h0, 33);
    send("mulh", 1'b1, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0022, 32'h0, MUL_STALL);
    send("mulhu", 1'b1, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0023, 32'hFFFFFFFE, MUL_STALL);
    send("mulhsu", 1'b1, 4'd2, 32'hFFFFFFFF, 32'h2, 16'h0024, 32'hFFFFFFFF, MUL_STALL);
    send("mul_neg", 1'b1, 4'd0, 32'hFFFFFFFD, 32'd5, 16'h0025, 32'hFFFFFFF1, MUL_STALL);
    send("div_neg", 1'b1, 4'd4, 32'hFFFFFFF9, 32'd2, 16'h0026, 32'hFFFFFFFD, 33);
    send("rem_neg", 1'b1, 4'd6, 32'hFFFFFFF9, 32'd2, 16'h0027, 32'hFFFFFFFF, 33);
    send("divu", 1'b1, 4'd5, 32'd100, 32'd7, 16'h0028, 32'd14, 33);
    send("add_after_md", 1'b0, 4'b0000, 32'd40, 32'd2, 16'h0029, 32'd42, 0);

    // Squash in BUSY iteration 10: no result, stall drops next cycle
    @(negedge clk);
    drive(1'b1, 4'd5, 32'd100, 32'd7, 16'h0030);
    repeat (11) @(negedge clk);
    #1;
    check("squash_busy_stall", 32'(ex_stall_o), 32'd1);
    squash_i = 1'b1;
    @(negedge clk);
    squash_i   = 1'b0;
    in_valid_i = 1'b0;
    in_md_i    = 1'b0;
    #1;
    check("squash_stall_low", 32'(ex_stall_o), 32'd0);
    check("squash_no_valid", 32'(out_valid_o), 32'd0);
    repeat (40) @(negedge clk);
    send("add_after_squash", 1'b0, 4'b0000, 32'd1, 32'd2, 16'h0031, 32'd3, 0);

    // Downstream stall holds a valid ALU result, then the held op completes
    @(negedge clk);
    stall_i = 1'b1;
    drive(1'b0, 4'b0000, 32'd10, 32'd10, 16'h0032);
    expect_out("add_held", 32'd20, 16'h0032);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_valid", 32'(out_valid_o), 32'd1);
      check("hold_result", out_result_o, 32'd3);
      @(negedge clk);
    end
    stall_i = 1'b0;
    @(posedge clk);
    idle();

    // REMU with stall_i held for 5 cycles starting in DONE
    @(negedge clk);
    drive(1'b1, 4'd7, 32'd100, 32'd7, 16'h0040);
    expect_out("remu_stalled", 32'd2, 16'h0040);
    repeat (33) @(negedge clk);
    stall_i = 1'b1;
    #1;
    check("done_stall_low", 32'(ex_stall_o), 32'd0);
    repeat (4) begin
      @(negedge clk);
      #1;
      check("done_hold_stall", 32'(ex_stall_o), 32'd0);
      check("done_hold_valid", 32'(out_valid_o), 32'd0);
    end
    @(negedge clk);
    stall_i = 1'b0;
    @(posedge clk);
    #1;
    check("remu_valid_after_release", 32'(out_valid_o), 32'd1);
    idle();

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    drive(1'b1, 4'd4, 32'd7, 32'd3, 16'h0050);
    repeat (5) @(negedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid_o), 32'd0);
    check("async_rst_stall", 32'(ex_stall_o), 32'd0);
    check("async_rst_result", out_result_o, 32'd0);
    check("async_rst_tag", 32'(out_tag_o), 32'd0);
    @(negedge clk);
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    in_md_i    = 1'b0;
    repeat (40) @(negedge clk);

    send("mul_3x5", 1'b1, 4'd0, 32'd3, 32'd5, 16'h0060, 32'd15, MUL_STALL);
    idle();
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
